// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared definitions for the pipelined single-precision adder
// (align stage, prefix-adder wrapper, normaliser).
//   - IEEE-754 single field widths and aligned-significand width
//   - default prefix-adder latency
//   - side_t: sideband that rides alongside the adder sum
//   - small unpack helpers used in the compare stage
package fp_add_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int SIG_W     = 24;               // hidden bit + fraction
  localparam int GRS_W     = 3;                // guard, round, sticky
  localparam int ALN_W     = SIG_W + GRS_W;    // 27-bit aligned significand
  localparam int ADDER_LAT = 5;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic             nan;
    logic             inf;
  } side_t;

  // Significand with the implicit bit restored (0 for zero/denormal).
  function automatic logic [SIG_W-1:0] unpack_sig(input logic [EXP_W-1:0]  e,
                                                  input logic [FRAC_W-1:0] f);
    return {|e, f};
  endfunction

  // Denormals share the weight of exponent 1.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

  function automatic logic is_nan(input logic [EXP_W-1:0]  e,
                                  input logic [FRAC_W-1:0] f);
    return (&e) && (|f);
  endfunction

  function automatic logic is_inf(input logic [EXP_W-1:0]  e,
                                  input logic [FRAC_W-1:0] f);
    return (&e) && !(|f);
  endfunction

endpackage

// File: rtl/sticky_shifter.sv
// sticky_shifter: combinational right shift of an aligned significand.
//   din_i  : W-bit value, low GRS bits already zero
//   sh_i   : shift distance
//   dout_o : din_i >> sh_i with every shifted-out bit ORed into bit 0;
//            at sh_i >= SAT only a single sticky bit survives.
module sticky_shifter #(
  parameter int W   = 27,
  parameter int SAT = 27
) (
  input  logic [W-1:0] din_i,
  input  logic [7:0]   sh_i,
  output logic [W-1:0] dout_o
);

  logic [W-1:0] shifted;
  logic [W-1:0] lost_mask;
  logic         sticky;

  always_comb begin
    shifted   = din_i >> sh_i;
    // Ones in exactly the bit positions that fall off the bottom.
    lost_mask = ~({W{1'b1}} << sh_i);
    sticky    = |(din_i & lost_mask);
    dout_o    = {shifted[W-1:1], shifted[0] | sticky};
    if (int'(sh_i) >= SAT)
      dout_o = {{(W-1){1'b0}}, |din_i};
  end

endmodule

// File: rtl/fp_align_stage.sv
// fp_align_stage: front end of the pipelined single-precision adder.
//   Stage 1 unpacks and orders the operands by magnitude and resolves
//   specials; stage 2 right-aligns the smaller significand with sticky;
//   stage 3 forms the 32-bit prefix-adder operands and carry-in.
//   The sideband is then delayed ADDER_LAT cycles so it meets the sum.
// Ports:
//   clk, clear_n          clock, synchronous active-low clear
//   in_valid, op_a, op_b  operand pair (IEEE-754 single)
//   sub                   1 = A-B
//   add_a/add_b/add_cin   adder operands, add_valid (3 cycles after input)
//   side_*                sign/exp/nan/inf, side_valid (3+ADDER_LAT cycles)
module fp_align_stage #(
  parameter int ADDER_LAT = fp_add_pkg::ADDER_LAT,
  parameter int SHIFT_SAT = 27
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        in_valid,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        sub,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  output logic        add_valid,
  output logic        side_valid,
  output logic        side_sign,
  output logic [7:0]  side_exp,
  output logic        side_nan,
  output logic        side_inf
);
  import fp_add_pkg::*;

  // ---------------- stage 1: unpack / compare / specials ----------------
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              sa, sb_eff, swap;
  logic              nan_a, nan_b, inf_a, inf_b;

  logic              s1_vld_d,  s1_vld_q;
  logic [SIG_W-1:0]  s1_ml_d,   s1_ml_q;
  logic [SIG_W-1:0]  s1_ms_d,   s1_ms_q;
  logic [EXP_W-1:0]  s1_diff_d, s1_diff_q;
  logic              s1_sub_d,  s1_sub_q;
  side_t             s1_side_d, s1_side_q;

  logic [EXP_W-1:0]  el, es;
  logic              sl, ss;

  always_comb begin
    ea     = op_a[30:23];
    eb     = op_b[30:23];
    fa     = op_a[22:0];
    fb     = op_b[22:0];
    sa     = op_a[31];
    sb_eff = op_b[31] ^ sub;
    // Ties keep A as the larger operand.
    swap   = op_b[30:0] > op_a[30:0];

    nan_a = is_nan(ea, fa);
    nan_b = is_nan(eb, fb);
    inf_a = is_inf(ea, fa);
    inf_b = is_inf(eb, fb);

    if (swap) begin
      sl = sb_eff;  el = eff_exp(eb);  s1_ml_d = unpack_sig(eb, fb);
      ss = sa;      es = eff_exp(ea);  s1_ms_d = unpack_sig(ea, fa);
    end else begin
      sl = sa;      el = eff_exp(ea);  s1_ml_d = unpack_sig(ea, fa);
      ss = sb_eff;  es = eff_exp(eb);  s1_ms_d = unpack_sig(eb, fb);
    end

    s1_vld_d  = in_valid;
    s1_sub_d  = sl ^ ss;
    s1_diff_d = el - es;

    // An Inf always sorts as the larger magnitude (only NaN beats it),
    // so the larger operand's sign is already the Inf's sign.
    s1_side_d.sign = sl;
    s1_side_d.exp  = el;
    s1_side_d.nan  = nan_a | nan_b | (inf_a & inf_b & (sa ^ sb_eff));
    s1_side_d.inf  = ~s1_side_d.nan & (inf_a | inf_b);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      s1_vld_q  <= 1'b0;
      s1_ml_q   <= '0;
      s1_ms_q   <= '0;
      s1_diff_q <= '0;
      s1_sub_q  <= 1'b0;
      s1_side_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_ml_q   <= s1_ml_d;
      s1_ms_q   <= s1_ms_d;
      s1_diff_q <= s1_diff_d;
      s1_sub_q  <= s1_sub_d;
      s1_side_q <= s1_side_d;
    end
  end

  // ---------------- stage 2: align ----------------
  logic [ALN_W-1:0] s2_small_d;
  logic [ALN_W-1:0] s2_large_q, s2_small_q;
  logic             s2_vld_q, s2_sub_q;
  side_t            s2_side_q;

  sticky_shifter #(.W(ALN_W), .SAT(SHIFT_SAT)) u_shift (
    .din_i  ({s1_ms_q, {GRS_W{1'b0}}}),
    .sh_i   (s1_diff_q),
    .dout_o (s2_small_d)
  );

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      s2_vld_q   <= 1'b0;
      s2_large_q <= '0;
      s2_small_q <= '0;
      s2_sub_q   <= 1'b0;
      s2_side_q  <= '0;
    end else begin
      s2_vld_q   <= s1_vld_q;
      s2_large_q <= {s1_ml_q, {GRS_W{1'b0}}};
      s2_small_q <= s2_small_d;
      s2_sub_q   <= s1_sub_q;
      s2_side_q  <= s1_side_q;
    end
  end

  // ---------------- stage 3: form adder operands ----------------
  // Subtract as large + ~small + 1; large >= small so the sum is
  // non-negative and the adder's carry-out carries no information.
  logic [31:0] add_a_d, add_b_d;
  logic [31:0] add_a_q, add_b_q;
  logic        add_cin_q, add_vld_q;
  side_t       s3_side_q;

  always_comb begin
    add_a_d = {{(32-ALN_W){1'b0}}, s2_large_q};
    add_b_d = {{(32-ALN_W){1'b0}}, s2_small_q};
    if (s2_sub_q)
      add_b_d = ~add_b_d;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      add_vld_q <= 1'b0;
      s3_side_q <= '0;
    end else begin
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= s2_sub_q;
      add_vld_q <= s2_vld_q;
      s3_side_q <= s2_side_q;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign add_valid = add_vld_q;

  // ---------------- sideband delay line ----------------
  // Matches the prefix adder's latency so side_* lands with the sum.
  logic  vld_pipe [ADDER_LAT];
  side_t side_pipe[ADDER_LAT];

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int i = 0; i < ADDER_LAT; i++) begin
        vld_pipe[i]  <= 1'b0;
        side_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0]  <= add_vld_q;
      side_pipe[0] <= s3_side_q;
      for (int i = 1; i < ADDER_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        side_pipe[i] <= side_pipe[i-1];
      end
    end
  end

  assign side_valid = vld_pipe[ADDER_LAT-1];
  assign side_sign  = side_pipe[ADDER_LAT-1].sign;
  assign side_exp   = side_pipe[ADDER_LAT-1].exp;
  assign side_nan   = side_pipe[ADDER_LAT-1].nan;
  assign side_inf   = side_pipe[ADDER_LAT-1].inf;

endmodule

// File: tb/tb_fp_align_stage.sv
// Bench for fp_align_stage: expected results come from a behavioural
// model and wait in two queues (adder side, sideband side) tagged with the
// cycle they are due; a negedge monitor pops and compares them and checks
// that valids are low in every cycle nothing is due.
module tb_fp_align_stage;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        in_valid;
  logic [31:0] op_a, op_b;
  logic        sub;
  logic [31:0] add_a, add_b;
  logic        add_cin, add_valid;
  logic        side_valid, side_sign, side_nan, side_inf;
  logic [7:0]  side_exp;

  fp_align_stage dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .in_valid   (in_valid),
    .op_a       (op_a),
    .op_b       (op_b),
    .sub        (sub),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_valid  (add_valid),
    .side_valid (side_valid),
    .side_sign  (side_sign),
    .side_exp   (side_exp),
    .side_nan   (side_nan),
    .side_inf   (side_inf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] a, b;
    logic        cin;
    logic        sg;
    logic [7:0]  ex;
    logic        nan, inf;
    int          due_a, due_s;
  } exp_t;

  exp_t qa[$];
  exp_t qs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s cyc=%0d got %h expected %h", tag, cyc, obs, req);
    end
  endtask

  // Arithmetic restatement: the shifted-out part is detected by shifting
  // back and comparing, saturation by distance.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t   r;
    logic   sx, sy, nx, ny, ix, iy, sl, ssm;
    int     ex, ey, el, es, d;
    longint mx, my, ml, ms, wide, sm;
    sx = x[31];
    sy = y[31] ^ s;
    ex = (x[30:23] == 0) ? 1 : int'(x[30:23]);
    ey = (y[30:23] == 0) ? 1 : int'(y[30:23]);
    mx = longint'(x[22:0]) + ((x[30:23] != 0) ? 64'd8388608 : 64'd0);
    my = longint'(y[22:0]) + ((y[30:23] != 0) ? 64'd8388608 : 64'd0);
    if (y[30:0] > x[30:0]) begin
      sl = sy; el = ey; ml = my; ssm = sx; es = ex; ms = mx;
    end else begin
      sl = sx; el = ex; ml = mx; ssm = sy; es = ey; ms = my;
    end
    d    = el - es;
    wide = ms * 8;
    if (d >= 27) sm = (ms != 0) ? 64'd1 : 64'd0;
    else begin
      sm = wide >> d;
      if ((sm << d) != wide) sm = sm | 64'd1;
    end
    r.a   = 32'(ml * 8);
    r.cin = sl ^ ssm;
    r.b   = r.cin ? ~32'(sm) : 32'(sm);
    nx = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    ny = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    ix = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    iy = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    r.nan = nx | ny | (ix & iy & (sx ^ sy));
    r.inf = !r.nan && (ix || iy);
    r.sg  = r.inf ? (ix ? sx : sy) : sl;
    r.ex  = 8'(el);
    r.due_a = 0;
    r.due_s = 0;
    return r;
  endfunction

  // Call #1 after a rising edge; returns #1 after the next one.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t e;
    e = model(x, y, s);
    e.due_a = cyc + 3;
    e.due_s = cyc + 8;
    qa.push_back(e);
    qs.push_back(e);
    op_a = x; op_b = y; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".add_a"},  add_a, 32'h0);
    chk({tag, ".add_b"},  add_b, 32'h0);
    chk({tag, ".cin"},    32'(add_cin), 32'h0);
    chk({tag, ".avld"},   32'(add_valid), 32'h0);
    chk({tag, ".svld"},   32'(side_valid), 32'h0);
    chk({tag, ".side"},   {21'h0, side_sign, side_exp, side_nan, side_inf}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (qa.size() > 0 && qa[0].due_a == cyc) begin
        exp_t e;
        e = qa.pop_front();
        chk("add_valid", 32'(add_valid), 32'h1);
        chk("add_a",     add_a, e.a);
        chk("add_b",     add_b, e.b);
        chk("add_cin",   32'(add_cin), 32'(e.cin));
      end else begin
        chk("add_idle", 32'(add_valid), 32'h0);
      end
      if (qs.size() > 0 && qs[0].due_s == cyc) begin
        exp_t e;
        e = qs.pop_front();
        chk("side_valid", 32'(side_valid), 32'h1);
        chk("side_sign",  32'(side_sign), 32'(e.sg));
        chk("side_exp",   32'(side_exp),  32'(e.ex));
        chk("side_nan",   32'(side_nan),  32'(e.nan));
        chk("side_inf",   32'(side_inf),  32'(e.inf));
      end else begin
        chk("side_idle", 32'(side_valid), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
    idle(2);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    clear_n = 1'b1;
    mon_en  = 1'b1;

    // 1..3 back to back with one bubble: valid pattern 1,1,0,1
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    issue(32'h3F80_0000, 32'h3F00_0000, 1'b1);
    idle(1);
    issue(32'h3F00_0000, 32'h4000_0000, 1'b0);
    // sticky and saturation
    issue(32'h3F80_0000, 32'h3380_0001, 1'b0);
    issue(32'h3F80_0000, 32'h0000_0001, 1'b0);
    // specials
    issue(32'h7F80_0000, 32'h7F80_0000, 1'b1);
    issue(32'h7F80_0000, 32'h3F80_0000, 1'b0);
    issue(32'h7FC0_0000, 32'h3F80_0000, 1'b0);
    issue(32'hFF80_0000, 32'h7F80_0000, 1'b1);
    issue(32'h3F80_0000, 32'hFF80_0000, 1'b0);
    // cancellation, denormal pair, sign from B after swap
    issue(32'h4120_0000, 32'h4120_0000, 1'b1);
    issue(32'h0000_0003, 32'h8040_0000, 1'b0);
    issue(32'h3F80_0000, 32'h4100_0000, 1'b1);
    idle(1);
    for (int i = 0; i < 12; i++) begin
      logic [31:0] rx, ry;
      rx = $urandom;
      ry = {$urandom_range(1, 0) == 1 ? rx[31:23] + 9'($urandom_range(30, 0)) : 9'($urandom), 23'($urandom)};
      issue(rx, ry, 1'($urandom));
      if ($urandom_range(3, 0) == 0) idle(1);
    end
    idle(10);

    // mid-stream clear: everything in flight is discarded
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    issue(32'h4000_0000, 32'h3F80_0000, 1'b1);
    issue(32'h7F80_0000, 32'h3F80_0000, 1'b0);
    clear_n = 1'b0;
    @(posedge clk); #1;
    clear_n = 1'b1;
    qa.delete();
    qs.delete();
    @(negedge clk);
    chk_all_zero("midclr");
    @(posedge clk); #1;
    idle(4);
    issue(32'h3F00_0000, 32'h4000_0000, 1'b0);
    idle(12);

    checks++;
    assert (qa.size() == 0 && qs.size() == 0) else begin
      errors++;
      $error("FAIL drain got %0d/%0d pending expected 0/0", qa.size(), qs.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
